// File: rtl/branch_predict_ctrl_if.sv
// branch_predict_ctrl_if: IF/EX/maintenance signals between the pipeline and the branch predictor
interface branch_predict_ctrl_if #(parameter int XLEN = 32);
   logic            pred_en;
   logic [XLEN-1:0] if_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            ex_valid;
   logic            ex_is_br;
   logic [XLEN-1:0] ex_pc;
   logic            ex_taken;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_target;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            inv_req;
   logic            busy;
   logic [31:0]     br_cnt;
   logic [31:0]     mis_cnt;
   modport master (
      output pred_en, if_pc, ex_valid, ex_is_br, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target, inv_req,
      input  pred_taken, pred_target, redirect, redirect_pc, busy, br_cnt, mis_cnt
   );
   modport slave (
      input  pred_en, if_pc, ex_valid, ex_is_br, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target, inv_req,
      output pred_taken, pred_target, redirect, redirect_pc, busy, br_cnt, mis_cnt
   );
endinterface

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: direct-mapped BTB with 2-bit counters, EX-side redirect and sweep invalidation
module branch_predict_ctrl #(
   parameter int IDX_W = 4,
   parameter int XLEN  = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   branch_predict_ctrl_if.slave bus
);
   localparam int N = 1 << IDX_W;
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic IDLE  = 1'b0;
   localparam logic SWEEP = 1'b1;
   logic             state;
   logic [IDX_W-1:0] idx;
   logic [N-1:0]     valid;
   logic [TAG_W-1:0] tag [N];
   logic [XLEN-1:0]  tgt [N];
   logic [1:0]       ctr [N];
   logic [IDX_W-1:0] fi, ei;
   logic             hit, ehit, res, trn;
   logic             unused_pc_lsbs;
   assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};
   assign fi   = bus.if_pc[IDX_W+1:2];
   assign ei   = bus.ex_pc[IDX_W+1:2];
   assign hit  = valid[fi] && tag[fi] == bus.if_pc[XLEN-1:IDX_W+2];
   assign ehit = valid[ei] && tag[ei] == bus.ex_pc[XLEN-1:IDX_W+2];
   assign bus.busy        = state == SWEEP;
   assign bus.pred_taken  = bus.pred_en && !bus.busy && hit && ctr[fi][1];
   assign bus.pred_target = bus.pred_taken ? tgt[fi] : bus.if_pc + XLEN'(4);
   assign res = bus.ex_valid && bus.ex_is_br;
   assign trn = res && bus.pred_en && !bus.busy;
   assign bus.redirect = res && (bus.ex_taken != bus.ex_pred_taken ||
                                 (bus.ex_taken && bus.ex_target != bus.ex_pred_target));
   assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         valid       <= '0;
         for (int i = 0; i < N; i++) ctr[i] <= 2'b01;
         bus.br_cnt  <= '0;
         bus.mis_cnt <= '0;
      end else begin
         if (state == IDLE && bus.inv_req) begin
            state <= SWEEP;
            idx   <= '0;
         end
         if (bus.busy) begin
            valid[idx] <= 1'b0;
            ctr[idx]   <= 2'b01;
            idx        <= idx + 1'b1;
            if (&idx) state <= IDLE;
         end
         // training never overlaps the sweep, so the two array writers cannot collide
         if (trn && ehit)
            ctr[ei] <= bus.ex_taken ? (ctr[ei] == 2'b11 ? 2'b11 : ctr[ei] + 2'b01)
                                    : (ctr[ei] == 2'b00 ? 2'b00 : ctr[ei] - 2'b01);
         else if (trn && bus.ex_taken) begin
            valid[ei] <= 1'b1;
            ctr[ei]   <= 2'b10;
         end
         bus.br_cnt  <= bus.br_cnt + {31'b0, res};
         bus.mis_cnt <= bus.mis_cnt + {31'b0, bus.redirect};
      end
   end
   always_ff @(posedge clk) begin
      if (trn && bus.ex_taken) begin
         tag[ei] <= bus.ex_pc[XLEN-1:IDX_W+2];
         tgt[ei] <= bus.ex_target;
      end
   end
endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Direct-mapped branch target buffer with 2-bit saturating direction counters for the five-stage RISC-V pipeline.
- **IF side:** supplies a predicted next PC to the PC mux.
- **EX side:** compares the resolved branch outcome from the branch controller against the carried prediction. On a mispredict it issues a same-cycle redirect and flush, then trains the table on the following edge.
- **Maintenance:** a sequential sweep invalidates the whole table on request.

## Interface
Parameters:
- IDX_W, 4, index width; table holds 2^IDX_W entries indexed by PC[IDX_W+1:2]
- XLEN, 32, address width; tag = PC[XLEN-1:IDX_W+2]

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- pred_en  in  1  1 = predict and train; 0 = static not-taken, no training
- if_pc  in  XLEN  fetch PC
- pred_taken  out  1  IF prediction: hit and counter[1]
- pred_target  out  XLEN  predicted target; equals if_pc+4 when pred_taken=0
- ex_valid  in  1  EX stage holds a real instruction
- ex_is_br  in  1  EX instruction is a conditional branch or jump
- ex_pc  in  XLEN  PC of the EX instruction
- ex_taken  in  1  resolved direction (PCSel selects ALU)
- ex_target  in  XLEN  resolved target (ALU result)
- ex_pred_taken  in  1  pred_taken carried down from IF
- ex_pred_target  in  XLEN  pred_target carried down from IF
- redirect  out  1  mispredict; PC mux takes redirect_pc; IF/ID must be cleared
- redirect_pc  out  XLEN  ex_target if ex_taken, else ex_pc+4
- inv_req  in  1  single-cycle request to invalidate all entries
- busy  out  1  invalidation sweep in progress
- br_cnt  out  32  resolved branches counted
- mis_cnt  out  32  mispredicts counted

## Operation
- **Entry contents:** valid, tag, target[XLEN-1:0], ctr[1:0].
- **Reset values:**
  - All valid=0, ctr=2'b01.
  - br_cnt=0, mis_cnt=0, busy=0, FSM=IDLE.
  - Outputs: pred_taken=0, redirect=0.
- **Prediction (combinational, asynchronous table read):**
  - hit = valid && tag==if_pc tag field.
  - pred_taken = pred_en && !busy && hit && ctr[1].
- **Resolution:** let `res` = ex_valid && ex_is_br. Then redirect = res && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)). redirect never asserts when `res`=0.
- **Training:** on the edge when `res` && pred_en && !busy. Entry i = ex_pc[IDX_W+1:2].
  - Hit, taken: ctr saturating increment (max 2'b11); target <= ex_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate, overwriting any prior entry: valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss, not taken: no change.
- **Statistics:** when `res`, br_cnt +1; when redirect, mis_cnt +1. Both counters wrap modulo 2^32 and count regardless of pred_en/busy.
- **FSM:**
  - IDLE --inv_req--> SWEEP (idx=0).
  - SWEEP clears valid[idx] and sets ctr[idx]=2'b01 each cycle, idx+1.
  - SWEEP --idx==2^IDX_W-1--> IDLE.
  - busy=1 exactly in SWEEP. inv_req while in SWEEP is ignored (not queued).
- **Boundaries:**
  - IF read of an entry trained the same cycle returns the pre-update contents.
  - Redirect stays correct during SWEEP and when pred_en=0; only prediction and training are suppressed.
  - An asynchronous reset mid-SWEEP returns to IDLE with all entries invalid.

## Timing
- pred_taken/pred_target: 0-cycle combinational from if_pc.
- redirect/redirect_pc: 0-cycle combinational from EX inputs, in the same cycle as the branch controller's Clear.
- Table and counter updates are visible on the cycle after the resolving cycle.
- Invalidation: inv_req sampled at edge t; busy=1 from t+1 through t+2^IDX_W; busy=0 at t+2^IDX_W+1; entries are cleared by index order.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; br_cnt=mis_cnt=0.
- Taken branch at ex_pc=0x100, ex_target=0x80, ex_pred_taken=0 -> redirect=1, redirect_pc=0x80, mis_cnt=1; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80, ctr=2'b10.
- Same branch resolves taken twice, then not taken -> ctr 2'b11, stays 2'b11, then 2'b10; the not-taken resolution with ex_pred_taken=1 gives redirect_pc=0x104.
- Alias: with IDX_W=4, allocate 0x100, then taken branch at 0x140 -> entry replaced; if_pc=0x100 -> pred_taken=0.
- inv_req for 1 cycle -> busy high 16 cycles; a second inv_req mid-sweep is ignored; afterwards all lookups miss; resolution during busy still redirects and counts, with no training.
- pred_en=0 with repeated taken branches -> pred_taken=0 throughout, every taken branch redirects, table unchanged.
